reg_debug_access: RTL and testbench

Debug-side initiator for the CPU register file. It takes read/write commands over a valid/ready channel and drives the register file write and rs1 ports, sharing them with the core through muxes. It returns read data or status over a valid/ready response channel. It sits between the debug transport and the register file in the Single_cycle core.

---
 rtl/reg_debug_access.sv | 107 ++++++++++
 tb/tb_reg_debug_access.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_debug_access.sv
// Debug-side initiator for the register file: accepts read/write commands, borrows the
// rs1 and writeback ports from the core when it can, and returns data or an error status.
module reg_debug_access #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_STALL = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              halted,
    input  logic              cpu_regwrite,
    input  logic [ADDR_W-1:0] cpu_rd,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [ADDR_W-1:0] cpu_rs1,
    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_rs1,
    input  logic [DATA_W-1:0] rf_rdata1
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          stall_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                dbg_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            stall_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        wr_q    <= cmd_write;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        stall_q <= '0;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (!halted) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= StResp;
                    end else if (!wr_q) begin
                        rsp_rdata_q <= rf_rdata1;
                        rsp_err_q   <= 1'b0;
                        state_q     <= StResp;
                    end else if (!cpu_regwrite) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= StResp;
                    end else if (stall_q == 4'(MAX_STALL)) begin
                        // Core kept the writeback port too long; give up without writing.
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        stall_q <= stall_q + 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Core writeback always wins, so a debug write only goes out on a free cycle.
    assign dbg_we = (state_q == StAccess) && halted && wr_q && !cpu_regwrite;

    assign rf_regwrite = cpu_regwrite | dbg_we;
    assign rf_rd       = dbg_we ? addr_q : cpu_rd;
    assign rf_wdata    = dbg_we ? wdata_q : cpu_wdata;
    assign rf_rs1      = ((state_q == StAccess) && !wr_q) ? addr_q : cpu_rs1;

endmodule

// File: tb/tb_reg_debug_access.sv
// Directed bench for reg_debug_access with a small behavioural register file attached.
module tb_reg_debug_access;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_STALL = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              halted = 1'b0;
    logic              cpu_regwrite = 1'b0;
    logic [ADDR_W-1:0] cpu_rd = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [ADDR_W-1:0] cpu_rs1 = '0;
    logic              rf_regwrite;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rf_rs1;
    logic [DATA_W-1:0] rf_rdata1;

    int checks = 0;
    int failures = 0;
    int dbg_wr_cnt = 0;

    logic [DATA_W-1:0] regs [32] = '{default: '0};

    always #5 clk = ~clk;

    reg_debug_access #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_STALL(MAX_STALL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .halted      (halted),
        .cpu_regwrite(cpu_regwrite),
        .cpu_rd      (cpu_rd),
        .cpu_wdata   (cpu_wdata),
        .cpu_rs1     (cpu_rs1),
        .rf_regwrite (rf_regwrite),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .rf_rs1      (rf_rs1),
        .rf_rdata1   (rf_rdata1)
    );

    // Register file model: x0 reads as zero, synchronous write.
    always @(posedge clk) begin
        if (rf_regwrite && rf_rd != 5'd0) regs[rf_rd] <= rf_wdata;
    end
    assign rf_rdata1 = (rf_rs1 == 5'd0) ? '0 : regs[rf_rs1];

    // Writes the core did not request must come from the debug side.
    always @(posedge clk) begin
        if (!rst && rf_regwrite && !cpu_regwrite) dbg_wr_cnt <= dbg_wr_cnt + 1;
    end

    task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d,
                          input int stall, input int hold, input logic [31:0] exp_rd,
                          input logic exp_err, output int lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 60) begin
            lat++;
            cpu_regwrite = (lat <= stall);
            cpu_rd       = 5'd10;
            cpu_wdata    = 32'hAAAA0000 + 32'(lat);
            @(negedge clk);
        end
        cpu_regwrite = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rsp_timeout: rsp_valid got %b expected 1", rsp_valid);
        end
        checks++;
        if (rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
            failures++;
            $display("FAIL rsp_value addr=%0d: got rdata=%h err=%b expected rdata=%h err=%b",
                     a, rsp_rdata, rsp_err, exp_rd, exp_err);
        end
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== exp_err ||
                cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL rsp_hold cycle %0d: got valid=%b rdata=%h err=%b ready=%b expected 1 %h %b 0",
                         h, rsp_valid, rsp_rdata, rsp_err, cmd_ready, exp_rd, exp_err);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rsp_release: got cmd_ready=%b rsp_valid=%b expected 1 0",
                     cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_rdata !== 32'h0 || rf_regwrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got ready=%b valid=%b err=%b rdata=%h we=%b expected 1 0 0 0 0",
                     cmd_ready, rsp_valid, rsp_err, rsp_rdata, rf_regwrite);
        end
        cpu_regwrite = 1'b1;
        cpu_rd       = 5'd3;
        cpu_wdata    = 32'h11;
        cpu_rs1      = 5'd4;
        #1;
        checks++;
        if (rf_regwrite !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h11 || rf_rs1 !== 5'd4) begin
            failures++;
            $display("FAIL core_passthru: got we=%b rd=%0d wdata=%h rs1=%0d expected 1 3 00000011 4",
                     rf_regwrite, rf_rd, rf_wdata, rf_rs1);
        end
        cpu_regwrite = 1'b0;
        cpu_rs1      = 5'd0;
    endtask

    task automatic test_write_read();
        int lat;
        int c0;
        halted = 1'b1;
        c0 = dbg_wr_cnt;
        do_cmd(1'b1, 5'd5, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0, lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL write_latency: got %0d expected 1", lat);
        end
        checks++;
        if (dbg_wr_cnt !== c0 + 1) begin
            failures++;
            $display("FAIL write_pulse: got %0d debug write cycles expected 1", dbg_wr_cnt - c0);
        end
        do_cmd(1'b0, 5'd5, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, lat);
        checks++;
        if (lat !== 1 || dbg_wr_cnt !== c0 + 1) begin
            failures++;
            $display("FAIL read_latency: got lat=%0d writes=%0d expected 1 1", lat, dbg_wr_cnt - c0);
        end
    endtask

    task automatic test_not_halted();
        int lat;
        int c0;
        c0 = dbg_wr_cnt;
        halted = 1'b0;
        do_cmd(1'b0, 5'd3, 32'h0, 0, 0, 32'h0, 1'b1, lat);
        do_cmd(1'b1, 5'd5, 32'h0BADF00D, 0, 0, 32'h0, 1'b1, lat);
        checks++;
        if (dbg_wr_cnt !== c0) begin
            failures++;
            $display("FAIL not_halted_write: got %0d debug writes expected 0", dbg_wr_cnt - c0);
        end
        halted = 1'b1;
        do_cmd(1'b0, 5'd5, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, lat);
    endtask

    task automatic test_stall();
        int lat;
        int c0;
        do_cmd(1'b1, 5'd7, 32'h12345678, 3, 0, 32'h0, 1'b0, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL stall_latency: got %0d expected 4", lat);
        end
        checks++;
        if (regs[10] !== 32'hAAAA0003) begin
            failures++;
            $display("FAIL core_wb: x10 got %h expected aaaa0003", regs[10]);
        end
        do_cmd(1'b0, 5'd7, 32'h0, 0, 0, 32'h12345678, 1'b0, lat);
        c0 = dbg_wr_cnt;
        do_cmd(1'b1, 5'd7, 32'h55555555, 20, 0, 32'h0, 1'b1, lat);
        checks++;
        if (lat < 15 || lat > 17 || dbg_wr_cnt !== c0) begin
            failures++;
            $display("FAIL stall_abort: got lat=%0d writes=%0d expected lat 15..17 writes 0",
                     lat, dbg_wr_cnt - c0);
        end
        do_cmd(1'b0, 5'd7, 32'h0, 0, 0, 32'h12345678, 1'b0, lat);
    endtask

    task automatic test_x0();
        int lat;
        int c0;
        c0 = dbg_wr_cnt;
        do_cmd(1'b1, 5'd0, 32'hFFFFFFFF, 0, 0, 32'h0, 1'b0, lat);
        checks++;
        if (dbg_wr_cnt !== c0 + 1) begin
            failures++;
            $display("FAIL x0_write_issued: got %0d writes expected 1", dbg_wr_cnt - c0);
        end
        do_cmd(1'b0, 5'd0, 32'h0, 0, 0, 32'h0, 1'b0, lat);
    endtask

    task automatic test_rsp_hold();
        int lat;
        do_cmd(1'b0, 5'd7, 32'h0, 0, 5, 32'h12345678, 1'b0, lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        int c0;
        c0 = dbg_wr_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 5'd9;
        cmd_wdata = 32'h99;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (rf_regwrite !== 1'b1 || rf_rd !== 5'd9) begin
            failures++;
            $display("FAIL access_write_drive: got we=%b rd=%0d expected 1 9", rf_regwrite, rf_rd);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rf_regwrite !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got we=%b ready=%b valid=%b expected 0 1 0",
                     rf_regwrite, cmd_ready, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || dbg_wr_cnt !== c0) begin
            failures++;
            $display("FAIL reset_mid_after: got valid=%b writes=%0d expected 0 0",
                     rsp_valid, dbg_wr_cnt - c0);
        end
        do_cmd(1'b0, 5'd9, 32'h0, 0, 0, 32'h0, 1'b0, lat);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_not_halted();
        test_stall();
        test_x0();
        test_rsp_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
